mult_seq: RTL and testbench
===========================

# mult_seq

Parametrised sequential shift-add multiplier, the successor to the fixed 8-bit unit. It multiplies two WIDTH-bit operands over exactly WIDTH work cycles and supports per-operation unsigned or two's-complement signed mode. It registers a full 2*WIDTH-bit product and flags completion with a one-cycle done pulse. It sits beside the datapath as a low-area multi-cycle arithmetic resource driven by a start/busy handshake.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_bi  input  WIDTH  multiplicand; sampled on start acceptance.
- b_bi  input  WIDTH  multiplier; sampled on start acceptance.
- signed_i  input  1  mode: 0 = unsigned, 1 = two's complement; sampled on start acceptance.
- start  input  1  request; accepted only in IDLE.
- busy_o  output  1  high while an operation is in progress.
- done_o  output  1  one-cycle pulse when y_bo is updated.
- y_bo  output  2*WIDTH  product; holds the last result until the next completion.

## Operation
- States: IDLE, WORK.
- IDLE with start=1:
  - Latch operand magnitudes a_mag and b_mag. In signed mode each magnitude is the absolute value of the operand; in unsigned mode it is the raw operand.
  - Latch neg = signed_i & (a_bi[WIDTH-1] ^ b_bi[WIDTH-1]).
  - Clear acc (2*WIDTH bits) and ctr ($clog2(WIDTH) bits).
  - Go to WORK.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits in WIDTH unsigned bits. No saturation is needed.
- Each WORK cycle: acc <= acc + ((a_mag & {WIDTH{b_mag[ctr]}}) << ctr), then ctr <= ctr + 1.
- The final WORK cycle is ctr == WIDTH-1. On that cycle:
  - y_bo <= neg ? -(acc + term) : (acc + term), where term is that cycle's partial product. The last partial product is included.
  - done_o <= 1.
  - Go to IDLE.
- ctr never wraps in normal operation; it is reloaded to 0 on every accept.
- start while busy_o=1 is ignored. It is not queued, and the operands and mode in flight are unaffected.
- Input changes while busy have no effect.
- Zero operands still take the full WIDTH cycles; there is no early termination.
- Reset asserted (low), at any time including mid-operation, asynchronously forces:
  - state=IDLE, busy_o=0, done_o=0, y_bo=0;
  - acc=0, ctr=0, a_mag=0, b_mag=0, neg=0.
- Reset values: busy_o 0, done_o 0, y_bo 0.

## Timing
- Start accepted at edge E0 (state IDLE, start=1): busy_o=1 from just after E0.
- WORK occupies edges E1..E(WIDTH). At edge E(WIDTH), y_bo is valid, done_o=1 and busy_o=0.
- Latency from the accepting edge to a valid y_bo is WIDTH cycles.
- done_o stays high for exactly one cycle, the cycle after E(WIDTH).
- If start is still high at E(WIDTH), it is ignored because state is WORK. The earliest next accept is E(WIDTH+1), so throughput is one result per WIDTH+1 cycles.
- busy_o is a registered state decode and has no combinational path from start.
- done_o is registered.

## Structure
- Shared package mult_pkg holds:
  - state encoding constants MULT_IDLE=1'b0 and MULT_WORK=1'b1;
  - a function for the counter width ($clog2 wrapper, minimum 1).
- One sub-module, mult_magnitude: parameter WIDTH; inputs val and signed_i; outputs mag (WIDTH bits) and sign. It is combinational and instantiated twice, once per operand.
- The rest is one always block for state/ctr/acc/y_bo/done_o with an asynchronous negedge reset.

## Test plan
- WIDTH=8, unsigned, 255 x 255 -> y_bo=16'hFE01 (65025) and done_o pulse exactly 8 cycles after the accepting edge; busy_o high for 8 cycles.
- WIDTH=8, signed:
  - -128 x -128 (8'h80 x 8'h80) -> 16'h4000;
  - -128 x 127 -> 16'hC080 (-16256);
  - 8'hFF x 8'h02 -> 16'hFFFE.
  - The same 8'hFF x 8'h02 in unsigned mode -> 16'h01FE.
- Start held high continuously, with operands 3x5 then 7x9 changing at the accepting edges -> y_bo=15 then 63. Accepts are 9 cycles apart, and the operands presented during busy are ignored.
- Reset driven low asynchronously mid-operation (between clock edges at cycle 4 of 8) -> busy_o, done_o and y_bo go to 0 immediately without a clock edge. After release, 6 x 7 completes to 42 with normal latency.
- WIDTH=16 and WIDTH=5 parameter sweep:
  - 16'hFFFF x 16'hFFFF unsigned -> 32'hFFFE0001 after 16 cycles;
  - WIDTH=5 signed -16 x -16 -> 10'h100.
  - Run against a random reference-model check over 1000 operations per width.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// state encoding and counter sizing.
package mult_pkg;

  typedef enum logic {
    MULT_IDLE = 1'b0,
    MULT_WORK = 1'b1
  } mult_state_t;

  // Counter width for WIDTH work cycles; never narrower than one bit.
  function automatic int ctr_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Request/response bundle between a datapath master and the mult_seq unit.
interface mult_seq_if
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
);
  // Handshake: start is taken only while busy_o is low (state IDLE); the edge that
  // takes it samples a_bi/b_bi/signed_i and raises busy_o. Anything presented while
  // busy_o is high is ignored. done_o pulses for one cycle when y_bo is updated, and
  // y_bo holds that product until the next completion.
  logic [WIDTH-1:0]   a_bi;
  logic [WIDTH-1:0]   b_bi;
  logic               signed_i;
  logic               start;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] y_bo;
  mult_state_t        dbg_state;

  modport master (
    output a_bi, b_bi, signed_i, start,
    input  busy_o, done_o, y_bo, dbg_state
  );

  modport slave (
    input  a_bi, b_bi, signed_i, start,
    output busy_o, done_o, y_bo, dbg_state
  );
endinterface

// File: rtl/mult_magnitude.sv
// Operand conditioning: absolute value in signed mode, raw value in unsigned mode.
module mult_magnitude #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] val,
  input  logic             signed_i,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  assign sign = signed_i & val[WIDTH-1];
  // The most negative value maps onto itself, which read unsigned is the right magnitude.
  assign mag  = sign ? -val : val;

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: WIDTH work cycles per product, unsigned or
// two's-complement per operation, registered 2*WIDTH-bit result with a done pulse.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  mult_seq_if.slave bus
);

  localparam int            CW   = ctr_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t        state;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      ctr;
  logic [2*WIDTH-1:0] y_q;
  logic               done_q;

  logic [WIDTH-1:0]   a_in_mag;
  logic [WIDTH-1:0]   b_in_mag;
  logic               a_sign;
  logic               b_sign;
  logic [2*WIDTH-1:0] term;
  logic [2*WIDTH-1:0] sum;

  mult_magnitude #(.WIDTH(WIDTH)) u_mag_a (
    .val      (bus.a_bi),
    .signed_i (bus.signed_i),
    .mag      (a_in_mag),
    .sign     (a_sign)
  );

  mult_magnitude #(.WIDTH(WIDTH)) u_mag_b (
    .val      (bus.b_bi),
    .signed_i (bus.signed_i),
    .mag      (b_in_mag),
    .sign     (b_sign)
  );

  // Partial product for the multiplier bit selected by ctr, aligned to its weight.
  assign term = {{WIDTH{1'b0}}, a_mag & {WIDTH{b_mag[ctr]}}} << ctr;
  assign sum  = acc + term;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= MULT_IDLE;
      a_mag  <= '0;
      b_mag  <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      ctr    <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MULT_IDLE: begin
          if (bus.start) begin
            a_mag <= a_in_mag;
            b_mag <= b_in_mag;
            neg   <= a_sign ^ b_sign;
            acc   <= '0;
            ctr   <= '0;
            state <= MULT_WORK;
          end
        end
        MULT_WORK: begin
          acc <= sum;
          if (ctr == LAST) begin
            y_q    <= neg ? -sum : sum;
            done_q <= 1'b1;
            state  <= MULT_IDLE;
          end else begin
            ctr <= ctr + 1'b1;
          end
        end
        default: state <= MULT_IDLE;
      endcase
    end
  end

  assign bus.busy_o    = (state == MULT_WORK);
  assign bus.done_o    = done_q;
  assign bus.y_bo      = y_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq at WIDTH 8, 16 and 5, checked against an arithmetic model.
module tb_mult_seq;
  import mult_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;

  mult_seq_if #(.WIDTH(8))  bus8 ();
  mult_seq_if #(.WIDTH(16)) bus16 ();
  mult_seq_if #(.WIDTH(5))  bus5 ();

  mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
  mult_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  mult_seq #(.WIDTH(5))  dut5  (.clk(clk), .reset(reset), .bus(bus5));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sel: 0 -> WIDTH 8, 1 -> WIDTH 16, 2 -> WIDTH 5
  function automatic int width_of(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 16 : 5;
  endfunction

  function automatic logic [63:0] get_y(input int sel);
    if (sel == 0) return {48'b0, bus8.y_bo};
    if (sel == 1) return {32'b0, bus16.y_bo};
    return {54'b0, bus5.y_bo};
  endfunction

  function automatic logic get_busy(input int sel);
    if (sel == 0) return bus8.busy_o;
    if (sel == 1) return bus16.busy_o;
    return bus5.busy_o;
  endfunction

  function automatic logic get_done(input int sel);
    if (sel == 0) return bus8.done_o;
    if (sel == 1) return bus16.done_o;
    return bus5.done_o;
  endfunction

  // Reference: sign-extend (if signed) to 64 bits, multiply, keep 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    logic [63:0] opmask, pmask, ae, be;
    opmask = (64'd1 << w) - 64'd1;
    pmask  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    ae = {32'b0, a} & opmask;
    be = {32'b0, b} & opmask;
    if (s && ae[w-1]) ae = ae | ~opmask;
    if (s && be[w-1]) be = be | ~opmask;
    return (ae * be) & pmask;
  endfunction

  // driver tasks
  task automatic drive(input int sel, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic st);
    case (sel)
      0: begin bus8.a_bi = a[7:0];   bus8.b_bi = b[7:0];   bus8.signed_i = s;  bus8.start = st;  end
      1: begin bus16.a_bi = a[15:0]; bus16.b_bi = b[15:0]; bus16.signed_i = s; bus16.start = st; end
      default: begin bus5.a_bi = a[4:0]; bus5.b_bi = b[4:0]; bus5.signed_i = s; bus5.start = st; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic st);
    case (sel)
      0: bus8.start = st;
      1: bus16.start = st;
      default: bus5.start = st;
    endcase
  endtask

  // Called #1 after the accepting edge; counts edges until done_o is seen.
  task automatic wait_done(input int sel, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (lat < 100) begin
      if (get_busy(sel)) busy_cnt++;
      if (get_done(sel)) break;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic s, output logic [63:0] y, output int lat,
                        output int busy_cnt);
    @(negedge clk);
    drive(sel, a, b, s, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    wait_done(sel, lat, busy_cnt);
    y = get_y(sel);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 32'd0, 32'd0, 1'b0, 1'b0);
    #2;
    for (int s = 0; s < 3; s++) begin
      total++;
      if (get_busy(s) !== 1'b0 || get_done(s) !== 1'b0 || get_y(s) !== 64'd0) begin
        bad++;
        $display("FAIL reset sel=%0d busy=%b done=%b y=%h required 0/0/0", s,
                 get_busy(s), get_done(s), get_y(s));
      end
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_unsigned_max;
    logic [63:0] y;
    int lat, bc;
    run_op(0, 32'd255, 32'd255, 1'b0, y, lat, bc);
    total++;
    if (y !== 64'hFE01) begin bad++; $display("FAIL umax_y got=%h required=fe01", y); end
    total++;
    if (lat !== 8) begin bad++; $display("FAIL umax_latency got=%0d required=8", lat); end
    total++;
    if (bc !== 8) begin bad++; $display("FAIL umax_busy_cycles got=%0d required=8", bc); end
    @(posedge clk);
    #1;
    total++;
    if (bus8.done_o !== 1'b0) begin bad++; $display("FAIL done_pulse_width done=%b required=0", bus8.done_o); end
  endtask

  task automatic test_signed_cases;
    logic [31:0] av[4] = '{32'h80, 32'h80, 32'hFF, 32'hFF};
    logic [31:0] bv[4] = '{32'h80, 32'h7F, 32'h02, 32'h02};
    logic        sv[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] ev[4] = '{64'h4000, 64'hC080, 64'hFFFE, 64'h01FE};
    logic [63:0] y;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(0, av[i], bv[i], sv[i], y, lat, bc);
      total++;
      if (y !== ev[i] || lat !== 8) begin
        bad++;
        $display("FAIL signed_case%0d y=%h lat=%0d required y=%h lat=8", i, y, lat, ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc, t0, t1;
    @(negedge clk);
    drive(0, 32'd3, 32'd5, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    t0 = cyc;
    drive(0, 32'd7, 32'd9, 1'b0, 1'b1);
    wait_done(0, lat, bc);
    total++;
    if (bus8.y_bo !== 16'd15 || lat !== 8) begin
      bad++;
      $display("FAIL b2b_first y=%0d lat=%0d required y=15 lat=8", bus8.y_bo, lat);
    end
    @(posedge clk);
    #1;
    t1 = cyc;
    total++;
    if (bus8.busy_o !== 1'b1 || (t1 - t0) !== 9) begin
      bad++;
      $display("FAIL b2b_accept_spacing busy=%b spacing=%0d required busy=1 spacing=9",
               bus8.busy_o, t1 - t0);
    end
    drive(0, 32'hC8, 32'h64, 1'b1, 1'b1);
    wait_done(0, lat, bc);
    set_start(0, 1'b0);
    total++;
    if (bus8.y_bo !== 16'd63 || lat !== 8) begin
      bad++;
      $display("FAIL b2b_second y=%0d lat=%0d required y=63 lat=8", bus8.y_bo, lat);
    end
  endtask

  task automatic test_async_reset;
    logic [63:0] y;
    int lat, bc;
    @(negedge clk);
    drive(0, 32'd100, 32'd200, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    set_start(0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total++;
    if (bus8.busy_o !== 1'b0 || bus8.done_o !== 1'b0 || bus8.y_bo !== 16'd0 ||
        bus8.dbg_state !== MULT_IDLE) begin
      bad++;
      $display("FAIL async_reset busy=%b done=%b y=%h required 0/0/0", bus8.busy_o,
               bus8.done_o, bus8.y_bo);
    end
    @(negedge clk);
    reset = 1'b1;
    run_op(0, 32'd6, 32'd7, 1'b0, y, lat, bc);
    total++;
    if (y !== 64'd42 || lat !== 8) begin
      bad++;
      $display("FAIL after_reset y=%0d lat=%0d required y=42 lat=8", y, lat);
    end
  endtask

  task automatic test_width_sweep;
    logic [63:0] y;
    int lat, bc;
    run_op(1, 32'hFFFF, 32'hFFFF, 1'b0, y, lat, bc);
    total++;
    if (y !== 64'hFFFE0001 || lat !== 16 || bc !== 16) begin
      bad++;
      $display("FAIL w16_max y=%h lat=%0d busy=%0d required y=fffe0001 lat=16 busy=16", y, lat, bc);
    end
    run_op(2, 32'h10, 32'h10, 1'b1, y, lat, bc);
    total++;
    if (y !== 64'h100 || lat !== 5) begin
      bad++;
      $display("FAIL w5_minneg y=%h lat=%0d required y=100 lat=5", y, lat);
    end
  endtask

  task automatic test_random;
    logic [63:0] y, exp_y;
    logic [31:0] a, b, mask;
    logic s;
    int lat, bc, w;
    for (int sel = 0; sel < 3; sel++) begin
      w = width_of(sel);
      mask = 32'((64'd1 << w) - 64'd1);
      for (int n = 0; n < 1000; n++) begin
        a = $urandom & mask;
        b = $urandom & mask;
        case ($urandom_range(0, 9))
          0: a = 32'd0;
          1: b = mask;
          2: a = 32'd1 << (w - 1);
          default: ;
        endcase
        s = 1'($urandom_range(0, 1));
        exp_y = ref_mul(w, a, b, s);
        run_op(sel, a, b, s, y, lat, bc);
        total++;
        if (y !== exp_y || lat !== w) begin
          bad++;
          $display("FAIL random w=%0d a=%h b=%h s=%b y=%h lat=%0d required y=%h lat=%0d",
                   w, a, b, s, y, lat, exp_y, w);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_unsigned_max();
    test_signed_cases();
    test_back_to_back();
    test_async_reset();
    test_width_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
